fsm_share_arbiter: RTL

FSM_SHARE_ARBITER -- requirements
Module: fsm_share_arbiter

---
 rtl/fsm_arb_pkg.sv | 6 +
 rtl/fsm_share_arbiter_if.sv | 17 +
 rtl/rr_arb2.sv | 13 +
 rtl/fsm_share_arbiter.sv | 57 +++++
 4 files changed

// File: rtl/fsm_arb_pkg.sv
// fsm_arb_pkg: shared types and constants for the shared-FSM arbiter
package fsm_arb_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;
  typedef logic [1:0] sym_t;
  localparam int MAX_BURST_DEF = 8;
endpackage

// File: rtl/fsm_share_arbiter_if.sv
// fsm_share_arbiter_if: requester side and shared-FSM side signals of the arbiter
interface fsm_share_arbiter_if;
  import fsm_arb_pkg::*;
  logic [1:0] req;
  sym_t sym0;
  sym_t sym1;
  logic [1:0] gnt;
  logic fsm_a;
  logic fsm_b;
  logic fsm_rst;
  logic [1:0] fsm_y;
  logic [1:0] y_out;
  logic y_valid;
  logic y_id;
  modport master (output req, sym0, sym1, fsm_y, input gnt, fsm_a, fsm_b, fsm_rst, y_out, y_valid, y_id);
  modport slave (input req, sym0, sym1, fsm_y, output gnt, fsm_a, fsm_b, fsm_rst, y_out, y_valid, y_id);
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin select; ptr is the last-served requester
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  output logic       sel,
  output logic       ptr
);
  assign sel = &req ? ~ptr : req[1];
  always_ff @(posedge clk)
    ptr <= rst ? 1'b1 : upd ? sel : ptr;
endmodule

// File: rtl/fsm_share_arbiter.sv
// fsm_share_arbiter: time-shares one Mealy FSM between two requesters (IDLE/SYNC/RUN)
// Optional BURST_LIMIT_EN preempts an owner after MAX_BURST steps when the other requester waits.
module fsm_share_arbiter
  import fsm_arb_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input logic clk,
  input logic rst,
  fsm_share_arbiter_if.slave bus
);
  state_t st, nx;
  logic ptr, sel, any, upd, own_req, step, preempt;
  sym_t sym;
  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_range
    $error("MAX_BURST out of range 1..15");
  end
  rr_arb2 u_rr (.clk(clk), .rst(rst), .req(bus.req), .upd(upd), .sel(sel), .ptr(ptr));
  // ptr doubles as the current owner: it is loaded with the winner on every SYNC entry
  assign any = |bus.req;
  assign own_req = bus.req[ptr];
  assign sym = ptr ? bus.sym1 : bus.sym0;
  assign step = st == RUN && own_req;
`ifdef BURST_LIMIT_EN
  localparam logic [3:0] LIM = 4'(MAX_BURST - 1);
  logic [3:0] cnt;
  always_ff @(posedge clk)
    if (rst || st == SYNC) cnt <= 4'd0;
    else if (step && cnt != 4'hf) cnt <= cnt + 4'd1;
  assign preempt = cnt >= LIM && bus.req[~ptr];
`else
  assign preempt = 1'b0;
`endif
  always_ff @(posedge clk)
    st <= rst ? IDLE : nx;
  always_comb begin
    nx = st == IDLE ? (any ? SYNC : IDLE) :
         st == SYNC ? RUN :
         (!own_req || preempt) ? (any ? SYNC : IDLE) : RUN;
    upd = nx == SYNC;
  end
  assign bus.gnt = (st == SYNC || step) ? (ptr ? 2'b10 : 2'b01) : 2'b00;
  assign bus.fsm_rst = st != RUN;
  assign {bus.fsm_a, bus.fsm_b} = step ? sym : 2'b00;
  always_ff @(posedge clk)
    if (rst) begin
      bus.y_out <= 2'b00;
      bus.y_valid <= 1'b0;
      bus.y_id <= 1'b0;
    end else begin
      bus.y_valid <= step;
      if (step) begin
        bus.y_out <= bus.fsm_y;
        bus.y_id <= ptr;
      end
    end
endmodule
